// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encodings and default geometry.
package pipelined_add_sub_pkg;

  typedef enum logic {
    ALU_OP_ADD = 1'b0,
    ALU_OP_SUB = 1'b1
  } alu_op_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  // SUB is a + ~b + 1, so the caller's carry-in is replaced by the +1.
  function automatic logic stage0_carry(input logic sub, input logic ci);
    return (alu_op_e'(sub) == ALU_OP_SUB) ? 1'b1 : ci;
  endfunction

endpackage

// File: rtl/pipelined_add_sub_slice.sv
// One pipeline stage worth of arithmetic: a combinational ripple of SLICE full-adder cells.
// Also exports the carry into the slice MSB so the top slice can form signed overflow.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic [SLICE-1:0] s_o,
  output logic             c_o,
  output logic             cmsb_o
);

  logic cy;

  always_comb begin
    cy     = c_i;
    cmsb_o = c_i;
    s_o    = '0;
    for (int i = 0; i < SLICE; i++) begin
      cmsb_o = cy;
      s_o[i] = a_i[i] ^ b_i[i] ^ cy;
      cy     = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
    end
    c_o = cy;
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/sub pipelined in SLICE-bit carry stages; latency WIDTH/SLICE cycles, 1 op/cycle.
// The whole pipe advances only when the output register is empty or being drained.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SLICE;

  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: SLICE must be >=1 and divide WIDTH");
  end

  // Rank 0 holds accepted operands; rank k+1 holds the result of slice k.
  logic [STAGES:0]  vld_q, vld_d;
  logic [STAGES:0]  c_q, c_d;
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES+1];
  logic [WIDTH-1:0] sum_d [STAGES+1];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0]  slice_sum;
  logic [STAGES-1:0] slice_co;
  logic [STAGES-1:0] slice_cmsb;
  logic              advance;

  assign advance = !vld_q[STAGES] || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a_i   (a_q[k][k*SLICE +: SLICE]),
      .b_i   (b_q[k][k*SLICE +: SLICE]),
      .c_i   (c_q[k]),
      .s_o   (slice_sum[k*SLICE +: SLICE]),
      .c_o   (slice_co[k]),
      .cmsb_o(slice_cmsb[k])
    );
  end

  always_comb begin
    vld_d[0] = in_valid;
    // Operand registers hold their value across bubbles; only the valid bit carries the bubble.
    a_d[0]   = in_valid ? a : a_q[0];
    b_d[0]   = in_valid ? ((alu_op_e'(sub) == ALU_OP_SUB) ? ~b : b) : b_q[0];
    c_d[0]   = in_valid ? stage0_carry(sub, ci) : c_q[0];
    sum_d[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k+1]                    = vld_q[k];
      c_d[k+1]                      = slice_co[k];
      sum_d[k+1]                    = sum_q[k];
      sum_d[k+1][k*SLICE +: SLICE]  = slice_sum[k*SLICE +: SLICE];
    end
    ovf_d  = slice_cmsb[STAGES-1] ^ slice_co[STAGES-1];
    zero_d = (sum_d[STAGES] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
      for (int k = 0; k <= STAGES; k++) begin
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES];
  assign sum       = sum_q[STAGES];
  assign co        = c_q[STAGES];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: a 16/4 instance and a 3/1 instance against an integer-arithmetic model.
module tb_pipelined_add_sub;

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        ci16 = 1'b0, sub16 = 1'b0, co16, ovf16, zero16;

  logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b1;
  logic [2:0]  a3 = '0, b3 = '0, sum3;
  logic        ci3 = 1'b0, sub3 = 1'b0, co3, ovf3, zero3;

  pipelined_add_sub #(.WIDTH(16), .SLICE(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .ci(ci16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .co(co16), .ovf(ovf16), .zero(zero16)
  );

  pipelined_add_sub #(.WIDTH(3), .SLICE(1)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .ci(ci3), .sub(sub3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .sum(sum3), .co(co3), .ovf(ovf3), .zero(zero3)
  );

  int total = 0;
  int bad   = 0;
  res_t exp16[$], got16[$], exp3[$], got3[$];

  // Reference: true integer results, unsigned for sum/carry, signed range test for overflow.
  function automatic res_t ref_model(input int w, input int av, input int bv, input bit civ, input bit subv);
    res_t r;
    int m, half, sa, sb, tu, ts;
    r    = '0;
    m    = 1 << w;
    half = m / 2;
    sa   = (av >= half) ? av - m : av;
    sb   = (bv >= half) ? bv - m : bv;
    if (subv) begin
      tu   = av - bv;
      ts   = sa - sb;
      r.co = (av >= bv);
    end else begin
      tu   = av + bv + int'(civ);
      ts   = sa + sb + int'(civ);
      r.co = (tu >= m);
    end
    tu     = ((tu % m) + m) % m;
    r.sum  = 16'(tu);
    r.ovf  = (ts < -half) || (ts > half - 1);
    r.zero = (tu == 0);
    return r;
  endfunction

  task automatic step16(input bit iv, input logic [15:0] av, input logic [15:0] bv,
                        input bit civ, input bit subv, input bit ordy, output bit acc);
    @(negedge clk);
    in_valid16 = iv; a16 = av; b16 = bv; ci16 = civ; sub16 = subv; out_ready16 = ordy;
    #1;
    acc = iv && in_ready16;
    if (out_valid16 && out_ready16) got16.push_back({sum16, co16, ovf16, zero16});
    if (acc) exp16.push_back(ref_model(16, int'(av), int'(bv), civ, subv));
  endtask

  task automatic step3(input bit iv, input logic [2:0] av, input logic [2:0] bv,
                       input bit civ, input bit subv, input bit ordy, output bit acc);
    @(negedge clk);
    in_valid3 = iv; a3 = av; b3 = bv; ci3 = civ; sub3 = subv; out_ready3 = ordy;
    #1;
    acc = iv && in_ready3;
    if (out_valid3 && out_ready3) got3.push_back({13'b0, sum3, co3, ovf3, zero3});
    if (acc) exp3.push_back(ref_model(3, int'(av), int'(bv), civ, subv));
  endtask

  task automatic test_reset;
    bit acc;
    #1;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid16); end
    total++; if (sum16 !== 16'h0000) begin bad++; $display("FAIL rst_sum got=%h want=0000", sum16); end
    total++; if ({co16, ovf16, zero16} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {co16, ovf16, zero16}); end
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready16); end
    total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL rst_out_valid3 got=%b want=0", out_valid3); end
    @(negedge clk);
    rst = 1'b0;
    got16.delete();
    for (int i = 0; i < 8; i++) step16(0, '0, '0, 0, 0, 1, acc);
    total++; if (got16.size() !== 0) begin bad++; $display("FAIL rst_idle_emit got=%0d want=0", got16.size()); end
  endtask

  logic [15:0] dva [5] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
  logic [15:0] dvb [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1234};
  bit          dvs [5] = '{0, 0, 1, 1, 1};
  logic [15:0] dws [5] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
  bit          dwc [5] = '{1, 0, 0, 1, 1};
  bit          dwo [5] = '{0, 1, 0, 1, 0};
  bit          dwz [5] = '{1, 0, 0, 0, 1};

  task automatic test_directed;
    bit   acc;
    int   lat;
    res_t r;
    for (int i = 0; i < 5; i++) begin
      exp16.delete(); got16.delete();
      step16(1, dva[i], dvb[i], 0, dvs[i], 1, acc);
      lat = -1;
      for (int j = 1; j <= 20; j++) begin
        step16(0, '0, '0, 0, 0, 1, acc);
        if (got16.size() > 0) begin lat = j - 1; break; end
      end
      r = (got16.size() > 0) ? got16[0] : '0;
      total++; if (lat !== 4) begin bad++; $display("FAIL dir%0d_latency got=%0d want=4", i, lat); end
      total++; if (r.sum !== dws[i]) begin bad++; $display("FAIL dir%0d_sum got=%h want=%h", i, r.sum, dws[i]); end
      total++; if (r.co !== dwc[i]) begin bad++; $display("FAIL dir%0d_co got=%b want=%b", i, r.co, dwc[i]); end
      total++; if (r.ovf !== dwo[i]) begin bad++; $display("FAIL dir%0d_ovf got=%b want=%b", i, r.ovf, dwo[i]); end
      total++; if (r.zero !== dwz[i]) begin bad++; $display("FAIL dir%0d_zero got=%b want=%b", i, r.zero, dwz[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] oa [8], ob [8];
    bit          oc [8], os [8];
    bit          acc, ordy;
    int          idx, cyc;
    logic [18:0] snap;
    exp16.delete(); got16.delete();
    for (int i = 0; i < 8; i++) begin
      oa[i] = 16'($urandom); ob[i] = 16'($urandom);
      oc[i] = 1'($urandom); os[i] = 1'($urandom);
    end
    idx = 0; cyc = 0; snap = '0;
    while (idx < 8 && cyc < 60) begin
      ordy = !(cyc >= 6 && cyc <= 8);
      // Garbage operands while stalled must not be taken.
      if (ordy) step16(1, oa[idx], ob[idx], oc[idx], os[idx], ordy, acc);
      else      step16(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy, acc);
      if (!ordy) begin
        total++; if (in_ready16 !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready16); end
        total++; if (out_valid16 !== 1'b1) begin bad++; $display("FAIL b2b_stall_out_valid cyc=%0d got=%b want=1", cyc, out_valid16); end
        if (cyc == 6) snap = {sum16, co16, ovf16, zero16};
        else begin
          total++;
          if ({sum16, co16, ovf16, zero16} !== snap) begin
            bad++; $display("FAIL b2b_hold cyc=%0d got=%h want=%h", cyc, {sum16, co16, ovf16, zero16}, snap);
          end
        end
      end else if (acc) idx++;
      cyc++;
    end
    total++; if (idx !== 8) begin bad++; $display("FAIL b2b_issue got=%0d want=8", idx); end
    for (int j = 0; j < 30 && got16.size() < 8; j++) step16(0, '0, '0, 0, 0, 1, acc);
    for (int j = 0; j < 4; j++) step16(0, '0, '0, 0, 0, 1, acc);
    total++; if (got16.size() !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got16.size()); end
    for (int i = 0; i < 8 && i < got16.size(); i++) begin
      total++;
      if (got16[i] !== exp16[i]) begin bad++; $display("FAIL b2b_result%0d got=%h want=%h", i, got16[i], exp16[i]); end
    end
  endtask

  task automatic test_random_stream;
    bit acc;
    int issued, cyc;
    logic [15:0] ra, rb;
    bit rc, rs, iv;
    exp16.delete(); got16.delete();
    issued = 0; cyc = 0;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    while (issued < 150 && cyc < 2000) begin
      iv = ($urandom_range(0, 3) != 0);
      step16(iv, ra, rb, rc, rs, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        issued++;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        if (issued % 3 == 0) rb = ra;
      end
      cyc++;
    end
    for (int j = 0; j < 40 && got16.size() < exp16.size(); j++) step16(0, '0, '0, 0, 0, 1, acc);
    total++; if (got16.size() !== 150) begin bad++; $display("FAIL rnd_count got=%0d want=150", got16.size()); end
    for (int i = 0; i < got16.size() && i < exp16.size(); i++) begin
      total++;
      if (got16[i] !== exp16[i]) begin bad++; $display("FAIL rnd_result%0d got=%h want=%h", i, got16[i], exp16[i]); end
    end
  endtask

  task automatic test_async_reset;
    bit   acc;
    res_t want;
    exp16.delete(); got16.delete();
    for (int i = 0; i < 5; i++) step16(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, acc);
    step16(0, '0, '0, 0, 0, 0, acc);
    total++; if (out_valid16 !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b want=1", out_valid16); end
    #1 rst = 1'b1;
    #1;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", out_valid16); end
    total++; if ({sum16, co16, ovf16, zero16} !== 19'h0) begin bad++; $display("FAIL arst_outputs got=%h want=0", {sum16, co16, ovf16, zero16}); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp16.delete(); got16.delete();
    for (int i = 0; i < 10; i++) step16(0, '0, '0, 0, 0, 1, acc);
    total++; if (got16.size() !== 0) begin bad++; $display("FAIL arst_stale got=%0d want=0", got16.size()); end
    step16(1, 16'h00F0, 16'h0F0F, 1, 0, 1, acc);
    for (int j = 0; j < 20 && got16.size() == 0; j++) step16(0, '0, '0, 0, 0, 1, acc);
    want = '{sum: 16'h1000, co: 1'b0, ovf: 1'b0, zero: 1'b0};
    total++;
    if (got16.size() !== 1 || got16[0] !== want) begin
      bad++; $display("FAIL arst_recover got_n=%0d got=%h want=%h", got16.size(), (got16.size() > 0) ? got16[0] : '0, want);
    end
  endtask

  task automatic test_w3_exhaustive;
    bit acc;
    int idx, cyc, sv, av, bv, cv;
    exp3.delete(); got3.delete();
    idx = 0; cyc = 0;
    while (idx < 256 && cyc < 3000) begin
      sv = idx / 128; av = (idx / 16) % 8; bv = (idx / 2) % 8; cv = idx % 2;
      step3(1, 3'(av), 3'(bv), cv[0], sv[0], 1'($urandom), acc);
      if (acc) idx++;
      cyc++;
    end
    for (int j = 0; j < 40 && got3.size() < exp3.size(); j++) step3(0, '0, '0, 0, 0, 1, acc);
    total++; if (got3.size() !== 256) begin bad++; $display("FAIL w3_count got=%0d want=256", got3.size()); end
    for (int i = 0; i < got3.size() && i < exp3.size(); i++) begin
      total++;
      if (got3[i] !== exp3[i]) begin bad++; $display("FAIL w3_result%0d got=%h want=%h", i, got3[i], exp3[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_stream();
    test_async_reset();
    test_w3_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
